// File: rtl/bcd_scan_pkg.sv
// -----------------------------------------------------------------------------
// bcd_scan_pkg
// Shared definitions for the multiplexed BCD indicator scan controller.
//   state_e   : scan FSM states (IDLE, SHOW, GAP)
//   BCD_MAX   : largest code the downstream 4-to-10 decoder can display
//   bcd_valid : 1 when a 4-bit code is a displayable decimal digit
// -----------------------------------------------------------------------------
package bcd_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_valid(input logic [3:0] code);
      return (code <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl
// Time-multiplexed scan controller for a DIGITS-digit decimal indicator that
// shares one active-low BCD-to-decimal decoder. A packed BCD frame is accepted
// over valid/ready into a pending (shadow) buffer, swapped into the active
// buffer at frame boundaries, and presented one digit at a time for DWELL
// cycles, separated by BLANK dark cycles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           scan enable; low forces the display dark (frame is kept)
//   in_valid     frame offered
//   in_ready     pending buffer free
//   in_bcd       packed frame, digit 0 in bits [3:0]
//   bcd_out      code to decoder {D,C,B,A}
//   bcd_en       decoder output enable (low = all decoder lines inactive)
//   digit_sel_n  active-low digit select, one-cold or all ones
//   err          active frame contains a code above 9 (updated on each load)
//   busy         a frame is being scanned
// All outputs are registered.
// -----------------------------------------------------------------------------
module bcd_scan_ctrl
   import bcd_scan_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1000,
   parameter int BLANK  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic [3:0]            bcd_out,
   output logic                  bcd_en,
   output logic [DIGITS-1:0]     digit_sel_n,
   output logic                  err,
   output logic                  busy
);

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

   // 1 when any digit of a frame cannot be shown by the decoder.
   function automatic logic frame_has_err(input logic [4*DIGITS-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_valid(f[4*i +: 4])) r = 1'b1;
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pending_full_q, pending_full_d;
   logic                  frame_held_q, frame_held_d;
   logic [4*DIGITS-1:0]   active_q, active_d;
   logic [4*DIGITS-1:0]   pending_q, pending_d;
   logic                  in_ready_q, in_ready_d;
   logic [3:0]            bcd_out_q, bcd_out_d;
   logic                  bcd_en_q, bcd_en_d;
   logic [DIGITS-1:0]     digit_sel_n_q, digit_sel_n_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;

   logic                  accept;
   logic                  load;
   logic [3:0]            code_d;

   // Next-state: FSM, buffers, and the registered outputs derived from the
   // next state so that what the outputs show always matches the new state.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      pending_full_d = pending_full_q;
      frame_held_d   = frame_held_q;
      active_d       = active_q;
      pending_d      = pending_q;
      err_d          = err_q;
      load           = 1'b0;
      code_d         = 4'd0;

      // in_ready is registered as !pending_full, so this is the live handshake.
      accept = in_valid && in_ready_q;

      if (!en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // A held frame lets the scan restart after en was dropped.
               if (pending_full_q || frame_held_q) begin
                  load    = pending_full_q;
                  idx_d   = '0;
                  cnt_d   = DWELL_LD;
                  state_d = SHOW;
               end
            end
            SHOW: begin
               if (cnt_q == '0) begin
                  cnt_d   = BLANK_LD;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  cnt_d   = DWELL_LD;
                  state_d = SHOW;
                  if (idx_q == LAST_IDX) begin
                     // Frame boundary: the only point a new frame may enter.
                     idx_d = '0;
                     load  = pending_full_q;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // load needs pending full and accept needs it empty, so they never
      // collide on the same edge.
      if (load) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
         frame_held_d   = 1'b1;
         err_d          = frame_has_err(pending_q);
      end
      if (accept) begin
         pending_d      = in_bcd;
         pending_full_d = 1'b1;
      end

      in_ready_d = !pending_full_d;
      busy_d     = (state_d != IDLE);

      if (state_d == SHOW) begin
         code_d        = active_d[4*int'(idx_d) +: 4];
         bcd_out_d     = code_d;
         bcd_en_d      = bcd_valid(code_d);
         digit_sel_n_d = ~(SEL_ONE << idx_d);
      end else begin
         // Dark: decoder disabled, no digit selected, code left unchanged.
         bcd_out_d     = bcd_out_q;
         bcd_en_d      = 1'b0;
         digit_sel_n_d = '1;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         idx_q          <= '0;
         pending_full_q <= 1'b0;
         frame_held_q   <= 1'b0;
         in_ready_q     <= 1'b1;
         bcd_out_q      <= 4'd0;
         bcd_en_q       <= 1'b0;
         digit_sel_n_q  <= '1;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         pending_full_q <= pending_full_d;
         frame_held_q   <= frame_held_d;
         in_ready_q     <= in_ready_d;
         bcd_out_q      <= bcd_out_d;
         bcd_en_q       <= bcd_en_d;
         digit_sel_n_q  <= digit_sel_n_d;
         err_q          <= err_d;
         busy_q         <= busy_d;
      end
   end

   // Frame buffers: contents are qualified by pending_full/frame_held, so
   // they need no reset.
   always_ff @(posedge clk) begin
      active_q  <= active_d;
      pending_q <= pending_d;
   end

   assign in_ready    = in_ready_q;
   assign bcd_out     = bcd_out_q;
   assign bcd_en      = bcd_en_q;
   assign digit_sel_n = digit_sel_n_q;
   assign err         = err_q;
   assign busy        = busy_q;

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexed scan controller for a multi-digit decimal indicator driven by a shared active-low BCD-to-decimal decoder. Accepts a packed BCD frame over a valid/ready handshake and double-buffers it. Presents one digit at a time to the decoder with a programmable dwell time. Inserts a blanking gap between digits to suppress ghosting, and flags non-decimal codes.

## Interface
- DIGITS, 4: number of scanned digits (2–8).
- DWELL, 1000: cycles each digit is driven (≥2).
- BLANK, 16: cycles with all digit selects off between digits (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- en  in  1  scan enable; low forces display dark.
- in_valid  in  1  frame offered.
- in_ready  out  1  pending buffer free.
- in_bcd  in  4*DIGITS  frame; digit 0 in bits [3:0].
- bcd_out  out  4  code to decoder, {D,C,B,A}.
- bcd_en  out  1  decoder output enable; low means all decoder lines inactive (high).
- digit_sel_n  out  DIGITS  active-low digit select, one-cold or all-ones.
- err  out  1  sticky: active frame holds a code >9.
- busy  out  1  a frame is being scanned.

## Operation
- Two registers: active frame (scanned) and pending frame (shadow) with a pending_full flag.
- Handshake: accept when in_valid && in_ready. in_ready = !pending_full. Data is captured into pending.
- States: IDLE, SHOW, GAP.
- IDLE: all outputs dark.
  - If pending_full && en: move pending to active, clear pending_full, idx=0, go to SHOW.
- SHOW: digit_sel_n[idx]=0. bcd_out=active[idx]. bcd_en=1 if code ≤9, else 0 (digit shown blank).
  - After DWELL cycles, go to GAP.
- GAP: digit_sel_n all ones, bcd_en=0, bcd_out holds.
  - After BLANK cycles with idx<DIGITS-1: idx+1, go to SHOW.
  - After BLANK cycles with idx=DIGITS-1 (frame boundary): if pending_full, swap pending into active and clear the flag. Then idx=0, go to SHOW. Without a pending frame, the active frame repeats indefinitely.
- err: at every load into active, err = OR over digits of (code>9). It holds until the next load.
- busy = state≠IDLE.
- en low in any state: go to IDLE on the next edge and keep the active frame.
  - Re-enable with pending empty: restart from IDLE at digit 0 of the held frame, i.e. IDLE goes to SHOW when (pending_full || frame_held) && en.
- Simultaneous accept and swap on the same edge: the swap takes the old pending contents, and the new frame lands in pending with pending_full=1. This case cannot occur while in_ready=0, so it only arises when pending was empty. In that case no swap happens and the new frame waits.
- Counter width is clog2(max(DWELL,BLANK)). The counter reloads on every state entry.

## Timing
- Reset values:
  - Outputs: in_ready=1, bcd_out=0, bcd_en=0, digit_sel_n=all ones, err=0, busy=0.
  - Internal: pending_full=0, frame_held=0, idx=0, state=IDLE.
- All outputs are registered; there is no combinational path from in_* to any output.
- Latency: accept at edge N from IDLE → pending_full at N → SHOW of digit 0 visible after edge N+1.
- One digit period = DWELL+BLANK cycles. One frame = DIGITS*(DWELL+BLANK) cycles.
- digit_sel_n never has two zeros. Every SHOW→SHOW digit change passes through ≥BLANK dark cycles.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronously), and both frames are discarded.

## Structure
- Shared package bcd_scan_pkg:
  - state enum {IDLE, SHOW, GAP};
  - constant BCD_MAX=4'd9;
  - function bcd_valid(code).
- Natural sub-module: bcd_dec10_n, the active-low 4-to-10 decoder with enable. Instantiate it only in the top-level display wrapper, not inside this block, so the bench observes bcd_out/bcd_en directly.

## Test plan
- Reset, then DIGITS=4, DWELL=4, BLANK=2, frame 0x1234 → digit_sel_n cycles 1110,1111,1101,1111,1011,1111,0111,1111. bcd_out shows 4,3,2,1 for 4 cycles each, with 2 dark cycles between.
- Frame 0x12A4 → err=1 after load. Digit 1 shows with bcd_en=0 and digit_sel_n=1101. Then load 0x0000 → err=0 at the swap.
- Offer a second frame mid-scan, then a third → second accepted, in_ready=0, third stalled. Second becomes active only after the digit-3 GAP. in_ready returns to 1 on the swap edge.
- en dropped during SHOW of digit 2 → next cycle all dark, busy=0. en raised → digit 0 of the same frame shown one cycle later.
- rst_n pulsed low mid-GAP → outputs at reset values before the next clock edge. Both frames lost, and the scan resumes only after a new accept.
- No new frame for 3 frame periods → identical digit sequence repeats with an exact period of DIGITS*(DWELL+BLANK)=24 cycles.
